sram_1w1r_fifo_ctrl: RTL and testbench

//  Single-clock FIFO controller that drives both ports of a freepdk45_sram_1w1r_40x240 macro.

---
 rtl/sram_1w1r_fifo_ctrl_if.sv | 22 ++
 rtl/sram_1w1r_fifo_ctrl.sv | 88 ++++++++
 tb/tb_sram_1w1r_fifo_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_1w1r_fifo_ctrl_if.sv
// Producer/consumer valid-ready stream bundle for the SRAM-backed FIFO controller.
// The controller takes the slave view; the producer/consumer side takes the master view.
interface sram_1w1r_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 240
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sram_1w1r_fifo_ctrl.sv
// FIFO controller driving a 1W1R SRAM macro plus a 2-entry output buffer that absorbs the macro's read latency.
// Latency: push to out_valid is 3 cycles; in_ready drops only when the macro is full, out_valid stalls never lose a word.
module sram_1w1r_fifo_ctrl #(
    parameter int DATA_WIDTH = 240,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    sram_1w1r_fifo_ctrl_if.slave         s,
    output logic [$clog2(DEPTH+3)-1:0]   level,
    output logic                         sram_csb0,
    output logic [ADDR_WIDTH-1:0]        sram_addr0,
    output logic [DATA_WIDTH-1:0]        sram_din0,
    output logic                         sram_csb1,
    output logic [ADDR_WIDTH-1:0]        sram_addr1,
    input  logic [DATA_WIDTH-1:0]        sram_dout1
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int LVL_W = $clog2(DEPTH+3);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH-1);
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      mem_cnt_q, mem_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            ocnt_q, ocnt_d;
    logic                  ohd_q, ohd_d;
    logic [DATA_WIDTH-1:0] obuf_q [2];

    logic       push, pop, issue;
    logic [2:0] occ;

    assign s.in_ready  = (mem_cnt_q != FULL_CNT);
    assign s.out_valid = (ocnt_q != 2'd0);
    assign s.out_data  = obuf_q[ohd_q];
    assign push        = s.in_valid & s.in_ready;
    assign pop         = s.out_valid & s.out_ready;

    // Only issue a read if the buffer will have room when the data lands next cycle.
    assign occ   = 3'(ocnt_q) + 3'(inflight_q);
    assign issue = (mem_cnt_q != '0) && (occ < (3'd2 + 3'(pop)));

    assign sram_csb0  = ~(push & rst_n);
    assign sram_addr0 = wr_ptr_q;
    assign sram_din0  = s.in_data;
    assign sram_csb1  = ~issue;
    assign sram_addr1 = rd_ptr_q;
    assign level      = LVL_W'(mem_cnt_q) + LVL_W'(inflight_q) + LVL_W'(ocnt_q);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
        if (issue) rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
        mem_cnt_d  = mem_cnt_q + CNT_W'(push) - CNT_W'(issue);
        inflight_d = issue;
        ocnt_d     = ocnt_q + 2'(inflight_q) - 2'(pop);
        ohd_d      = pop ? ~ohd_q : ohd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
            ocnt_q     <= 2'd0;
            ohd_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
            ocnt_q     <= ocnt_d;
            ohd_q      <= ohd_d;
        end
    end

    // Macro data is only valid on the edge right after the issue cycle; capture lands at the tail slot.
    always_ff @(posedge clk) begin
        if (inflight_q) obuf_q[ohd_q ^ ocnt_q[0]] <= sram_dout1;
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && issue && (wr_ptr_q == rd_ptr_q)));
endmodule

// File: tb/tb_sram_1w1r_fifo_ctrl.sv
// Bench for sram_1w1r_fifo_ctrl: behavioural macro model plus a queue-based reference of the FIFO contents.
module tb_sram_1w1r_fifo_ctrl;
    localparam int DW    = 240;
    localparam int AW    = 6;
    localparam int DEPTH = 40;
    localparam int LW    = $clog2(DEPTH+3);

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    sram_1w1r_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus();
    logic [LW-1:0] level;
    logic          sram_csb0, sram_csb1;
    logic [AW-1:0] sram_addr0, sram_addr1;
    logic [DW-1:0] sram_din0, sram_dout1;

    sram_1w1r_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .s(bus), .level(level),
        .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    // Macro model: data appears at the negedge after the read is latched and goes X at the next posedge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          rd_pend;
    logic [AW-1:0] rd_a;
    always @(clk) begin
        if (clk) begin
            if (sram_csb0 === 1'b0) mem[sram_addr0] <= sram_din0;
            rd_pend    <= (sram_csb1 === 1'b0);
            rd_a       <= sram_addr1;
            sram_dout1 <= 'x;
        end else if (rd_pend === 1'b1) begin
            sram_dout1 <= mem[rd_a];
        end
    end

    typedef struct {
        logic          push, pop, ovld, ordy, csb0, csb1;
        logic [DW-1:0] got, exp;
        logic [AW-1:0] a0, a1;
        logic [LW-1:0] lvl;
        int            exp_lvl;
    } obs_t;

    logic [DW-1:0] q[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w = '0;
        for (int i = 0; i < 8; i++) w = {w[DW-33:0], 32'($urandom())};
        return w;
    endfunction

    // One clock of stimulus, entered and left at a negedge; updates the reference queue.
    task automatic do_cycle(input logic iv, input logic [DW-1:0] d, input logic ordy, output obs_t o);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        o.push = iv & bus.in_ready;
        o.ovld = bus.out_valid;
        o.ordy = ordy;
        o.pop  = bus.out_valid & ordy;
        o.got  = bus.out_data;
        o.csb0 = sram_csb0;
        o.csb1 = sram_csb1;
        o.a0   = sram_addr0;
        o.a1   = sram_addr1;
        o.lvl  = level;
        o.exp_lvl = q.size();
        o.exp  = 'x;
        if (o.pop && q.size() > 0) o.exp = q.pop_front();
        if (o.push) q.push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = rand_word();
        bus.out_ready = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        total++; if (sram_csb0 !== 1'b1) begin bad++; $display("FAIL reset_csb0 got=%b exp=1", sram_csb0); end
        total++; if (sram_csb1 !== 1'b1) begin bad++; $display("FAIL reset_csb1 got=%b exp=1", sram_csb1); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [DW-1:0] a5 = {30{8'hA5}};
        bus.in_valid = 1'b1; bus.in_data = a5; bus.out_ready = 1'b0;
        #1;
        total++; if (sram_csb0 !== 1'b0 || sram_addr0 !== '0 || sram_din0 !== a5) begin
            bad++; $display("FAIL single_write csb0=%b addr0=%0d exp csb0=0 addr0=0", sram_csb0, sram_addr0); end
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0; #1;
        total++; if (sram_csb0 !== 1'b1) begin bad++; $display("FAIL single_csb0_pulse got=%b exp=1", sram_csb0); end
        total++; if (sram_csb1 !== 1'b0 || sram_addr1 !== '0) begin
            bad++; $display("FAIL single_issue csb1=%b addr1=%0d exp csb1=0 addr1=0", sram_csb1, sram_addr1); end
        @(posedge clk); @(negedge clk); #1;
        total++; if (bus.out_valid !== 1'b0 || level !== LW'(1)) begin
            bad++; $display("FAIL single_n2 out_valid=%b level=%0d exp 0/1", bus.out_valid, level); end
        @(posedge clk); @(negedge clk); #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== a5 || level !== LW'(1)) begin
            bad++; $display("FAIL single_n3 out_valid=%b level=%0d data=%h exp 1/1/%h", bus.out_valid, level, bus.out_data, a5); end
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0; #1;
        total++; if (bus.out_valid !== 1'b0 || level !== '0) begin
            bad++; $display("FAIL single_pop out_valid=%b level=%0d exp 0/0", bus.out_valid, level); end
        @(negedge clk);
    endtask

    task automatic test_fill();
        obs_t o;
        int acc = 0;
        int n = 0;
        int guard = 0;
        logic [DW-1:0] w = rand_word();
        for (int i = 0; i < 45; i++) begin
            do_cycle(1'b1, w, 1'b0, o);
            if (o.push) begin acc++; w = rand_word(); end
        end
        for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, 1'b0, o);
        total++; if (acc != DEPTH+2) begin bad++; $display("FAIL fill_accepted got=%0d exp=%0d", acc, DEPTH+2); end
        total++; if (level !== LW'(DEPTH+2)) begin bad++; $display("FAIL fill_level got=%0d exp=%0d", level, DEPTH+2); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b exp=0", bus.in_ready); end
        while (q.size() > 0 && guard < 200) begin
            do_cycle(1'b0, '0, 1'b1, o);
            guard++;
            if (o.pop) begin
                n++;
                total++; if (o.got !== o.exp) begin bad++; $display("FAIL fill_drain_data idx=%0d got=%h exp=%h", n, o.got, o.exp); end
            end
        end
        total++; if (n != DEPTH+2 || q.size() != 0) begin bad++; $display("FAIL fill_drain_count got=%0d exp=%0d left=%0d", n, DEPTH+2, q.size()); end
        do_cycle(1'b0, '0, 1'b0, o);
        total++; if (o.ovld !== 1'b0 || o.lvl !== '0) begin bad++; $display("FAIL fill_empty out_valid=%b level=%0d exp 0/0", o.ovld, o.lvl); end
    endtask

    task automatic test_wrap();
        obs_t o;
        int acc = 0, pops = 0, collide = 0, guard = 0;
        int last_a0 = -1, last_a1 = -1;
        logic w0 = 1'b0, w1 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            do_cycle(1'b1, DW'(i), 1'b1, o);
            if (o.push) begin
                acc++;
                if (last_a0 == DEPTH-1 && o.a0 == '0) w0 = 1'b1;
                last_a0 = int'(o.a0);
            end
            if (o.csb1 === 1'b0) begin
                if (last_a1 == DEPTH-1 && o.a1 == '0) w1 = 1'b1;
                last_a1 = int'(o.a1);
            end
            if (o.csb0 === 1'b0 && o.csb1 === 1'b0 && o.a0 == o.a1) collide++;
            if (o.pop) begin
                pops++;
                total++; if (o.got !== o.exp) begin bad++; $display("FAIL wrap_data got=%h exp=%h", o.got, o.exp); end
            end
        end
        total++; if (acc != 100) begin bad++; $display("FAIL wrap_in_rate got=%0d exp=100", acc); end
        total++; if (pops < 97) begin bad++; $display("FAIL wrap_out_rate got=%0d exp>=97", pops); end
        while (q.size() > 0 && guard < 20) begin
            do_cycle(1'b0, '0, 1'b1, o);
            guard++;
            if (o.pop) begin
                total++; if (o.got !== o.exp) begin bad++; $display("FAIL wrap_tail_data got=%h exp=%h", o.got, o.exp); end
            end
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL wrap_drain left=%0d exp=0", q.size()); end
        total++; if (!w0 || !w1) begin bad++; $display("FAIL wrap_addr_wrap addr0=%b addr1=%b exp 1/1", w0, w1); end
        total++; if (collide != 0) begin bad++; $display("FAIL wrap_same_addr got=%0d exp=0", collide); end
    endtask

    task automatic test_backpressure();
        obs_t o, prev;
        int guard = 0;
        prev.ovld = 1'b0; prev.ordy = 1'b1; prev.got = '0;
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'b1, rand_word(), 1'($urandom_range(0, 1)), o);
            total++; if (o.lvl !== LW'(o.exp_lvl)) begin bad++; $display("FAIL bp_level cyc=%0d got=%0d exp=%0d", i, o.lvl, o.exp_lvl); end
            if (prev.ovld && !prev.ordy) begin
                total++; if (o.ovld !== 1'b1 || o.got !== prev.got) begin
                    bad++; $display("FAIL bp_hold cyc=%0d valid=%b got=%h exp=%h", i, o.ovld, o.got, prev.got); end
            end
            if (o.pop) begin
                total++; if (o.got !== o.exp) begin bad++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, o.got, o.exp); end
            end
            prev = o;
        end
        while (q.size() > 0 && guard < 200) begin
            do_cycle(1'b0, '0, 1'b1, o);
            guard++;
            if (o.pop) begin
                total++; if (o.got !== o.exp) begin bad++; $display("FAIL bp_drain_data got=%h exp=%h", o.got, o.exp); end
            end
        end
        do_cycle(1'b0, '0, 1'b0, o);
        total++; if (q.size() != 0 || o.ovld !== 1'b0) begin bad++; $display("FAIL bp_drain left=%0d out_valid=%b exp 0/0", q.size(), o.ovld); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic found = 1'b0;
        logic [DW-1:0] b = rand_word();
        do_cycle(1'b1, rand_word(), 1'b0, o);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            #1;
            if (sram_csb1 === 1'b0) found = 1'b1;
            else begin @(posedge clk); @(negedge clk); end
        end
        total++; if (!found) begin bad++; $display("FAIL rmid_issue got=none exp=issue"); end
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        total++; if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1 || bus.out_valid !== 1'b0 || level !== '0) begin
            bad++; $display("FAIL rmid_async csb0=%b csb1=%b out_valid=%b level=%0d exp 1/1/0/0", sram_csb0, sram_csb1, bus.out_valid, level); end
        @(negedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        do_cycle(1'b1, b, 1'b0, o);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            do_cycle(1'b0, '0, 1'b0, o);
            if (bus.out_valid === 1'b1) found = 1'b1;
        end
        total++; if (!found || bus.out_data !== b || level !== LW'(1)) begin
            bad++; $display("FAIL rmid_new_word valid=%b level=%0d got=%h exp=%h", found, level, bus.out_data, b); end
        do_cycle(1'b0, '0, 1'b1, o);
        total++; if (o.got !== o.exp) begin bad++; $display("FAIL rmid_pop got=%h exp=%h", o.got, o.exp); end
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, '0, 1'b1, o);
            total++; if (o.ovld !== 1'b0 || o.lvl !== '0) begin
                bad++; $display("FAIL rmid_stale cyc=%0d out_valid=%b level=%0d exp 0/0", i, o.ovld, o.lvl); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
